// File: rtl/alu_pipe.sv
// Handshaked ALU with one result register: single-cycle ops, plus a shift-add multiplier
// that needs WIDTH+1 cycles per result. The flags are registered together with y.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBB = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_SAR = 4'hD;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, next_state;
  logic             accept, load_alu, load_mul, mul_done;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] alu_y, wr_y;
  logic             alu_c, alu_v, alu_e;
  logic             wr_c, wr_v, wr_e;
  logic [W2-1:0]    prod, mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  // The result register can also be replaced while DONE, provided the consumer drains it on that same edge.
  assign in_ready  = rst_n && ((state == IDLE) || (state == DONE && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_done  = (state == BUSY) && (cnt == CW'(WIDTH));

  // Single-cycle ALU; the carry register doubles as the stored carry-in for ADC/SBB.
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    sum   = {1'b0, a} + {1'b0, b} + W1'(op == OP_ADC && carry);
    dif   = {1'b0, a} - {1'b0, b} - W1'(op == OP_SBB && carry);
    case (op)
      OP_ADD, OP_ADC: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        alu_y = dif[WIDTH-1:0];
        alu_c = dif[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_NOT: alu_y = ~a;
      OP_SHL: begin
        alu_y = {a[WIDTH-2:0], 1'b0};
        alu_c = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_y = {1'b0, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      OP_MUL: begin
        alu_y = '0;
      end
      OP_ROL: begin
        alu_y = {a[WIDTH-2:0], a[WIDTH-1]};
        alu_c = a[WIDTH-1];
      end
      OP_ROR: begin
        alu_y = {a[0], a[WIDTH-1:1]};
        alu_c = a[0];
      end
      OP_SAR: begin
        alu_y = {a[WIDTH-1], a[WIDTH-1:1]};
        alu_c = a[0];
      end
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    wr_y = mul_done ? prod[WIDTH-1:0] : alu_y;
    wr_c = mul_done ? (|prod[W2-1:WIDTH]) : alu_c;
    wr_v = mul_done ? 1'b0 : alu_v;
    wr_e = mul_done ? 1'b0 : alu_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            load_mul   = 1'b1;
            next_state = BUSY;
          end else begin
            load_alu   = 1'b1;
            next_state = DONE;
          end
        end else if (state == DONE && out_ready) begin
          next_state = IDLE;
        end
      end
      BUSY:    if (mul_done) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Result/flag register plus the multiplier: one partial product per cycle, then one write-back cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      if (load_alu || mul_done) begin
        y     <= wr_y;
        carry <= wr_c;
        zero  <= (wr_y == '0);
        neg   <= wr_y[WIDTH-1];
        ovf   <= wr_v;
        err   <= wr_e;
      end
      if (load_mul) begin
        prod   <= '0;
        mcand  <= W2'(a);
        mplier <= b;
        cnt    <= '0;
      end else if (state == BUSY && !mul_done) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8. Each result is queued when its op is accepted
// and compared when the consumer takes it.
module tb_alu_pipe;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBB = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_SAR = 4'hD;

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       e;
  } exp_t;

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [3:0] op;
  logic       carry, zero, neg, ovf, err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic model_c = 1'b0;
  exp_t sb[$];
  exp_t got, want;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [7:0] ry, input logic c, input logic z,
                              input logic n, input logic v, input logic e);
    return {ry, c, z, n, v, e};
  endfunction

  // Reference model written in integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input int x, input int w, input logic cin);
    exp_t e;
    int   r, sx, sw, ss, ci;
    e  = '0;
    r  = 0;
    ci = ((o == OP_ADC || o == OP_SBB) && cin) ? 1 : 0;
    sx = (x >= 128) ? x - 256 : x;
    sw = (w >= 128) ? w - 256 : w;
    case (o)
      OP_ADD, OP_ADC: begin
        r = x + w + ci; e.c = (r > 255);
        ss = sx + sw + ci; e.v = (ss > 127 || ss < -128);
      end
      OP_SUB, OP_SBB: begin
        r = x - w - ci; e.c = (r < 0);
        ss = sx - sw - ci; e.v = (ss > 127 || ss < -128);
      end
      OP_AND: r = x & w;
      OP_OR:  r = x | w;
      OP_XOR: r = x ^ w;
      OP_NOT: r = 255 - x;
      OP_SHL: begin r = x * 2;                  e.c = (x >= 128); end
      OP_SHR: begin r = x / 2;                  e.c = (x % 2 == 1); end
      OP_MUL: begin r = x * w;                  e.c = (r > 255); end
      OP_ROL: begin r = x * 2 + x / 128;        e.c = (x >= 128); end
      OP_ROR: begin r = x / 2 + (x % 2) * 128;  e.c = (x % 2 == 1); end
      OP_SAR: begin r = x / 2 + (x / 128) * 128; e.c = (x % 2 == 1); end
      default: e.e = 1'b1;
    endcase
    e.y = 8'(r);
    e.z = (e.y == 8'd0);
    e.n = e.y[7];
    return e;
  endfunction

  // Scoreboard: compare every result the consumer takes.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got y=%02h with empty scoreboard, required no out_valid", y);
      end else begin
        want = sb.pop_front();
        got  = {y, carry, zero, neg, ovf, err};
        if (got !== want) begin
          errors++;
          $display("FAIL result: got y=%02h c=%0b z=%0b n=%0b v=%0b e=%0b, required y=%02h c=%0b z=%0b n=%0b v=%0b e=%0b",
                   got.y, got.c, got.z, got.n, got.v, got.e, want.y, want.c, want.z, want.n, want.v, want.e);
        end
      end
    end
  end

  // Present one op, wait (bounded) for acceptance, queue its expected result.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] w,
                      input exp_t e, output int acc);
    int waited;
    in_valid = 1'b1; op = o; a = x; b = w;
    waited = 0;
    acc = -1;
    #1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
      out_ready = 1'b1;
      #1;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: op=%0h in_ready=%0b after %0d cycles, required 1", o, in_ready, waited);
      in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      model_c = e.c;
      acc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, y, carry, zero, neg, ovf, err} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %04h, required 0000", {out_valid, y, carry, zero, neg, ovf, err});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %0b, required 0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_arith;
    int t;
    send(OP_ADD, 8'd200, 8'd100, mk(8'd44, 1, 0, 0, 0, 0), t);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL add_latency: out_valid=%0b the cycle after accept, required 1", out_valid);
    end
    send(OP_ADC, 8'd1, 8'd1, mk(8'd3, 0, 0, 0, 0, 0), t);
    send(OP_SUB, 8'd5, 8'd5, mk(8'd0, 0, 1, 0, 0, 0), t);
    send(OP_SUB, 8'd3, 8'd10, mk(8'd249, 1, 0, 1, 0, 0), t);
    send(OP_SBB, 8'd10, 8'd3, mk(8'd6, 0, 0, 0, 0, 0), t);
    send(OP_ADD, 8'd100, 8'd100, mk(8'd200, 0, 0, 1, 1, 0), t);
    send(OP_SUB, 8'h80, 8'd1, mk(8'h7F, 0, 0, 0, 1, 0), t);
  endtask

  task automatic test_mul;
    int t, k;
    logic rdy_seen;
    out_ready = 1'b1;
    send(OP_MUL, 8'd20, 8'd20, mk(8'd144, 1, 0, 1, 0, 0), t);
    k = 0;
    rdy_seen = 1'b0;
    while (!out_valid && k < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k !== 9) begin
      errors++; $display("FAIL mul_latency: out_valid after %0d cycles, required 9", k);
    end
    checks++;
    if (rdy_seen !== 1'b0) begin
      errors++; $display("FAIL mul_busy_ready: in_ready=%0b while busy, required 0", rdy_seen);
    end
    send(OP_MUL, 8'd15, 8'd17, mk(8'd255, 0, 0, 1, 0, 0), t);
    send(OP_MUL, 8'd0, 8'd99, mk(8'd0, 0, 1, 0, 0, 0), t);
  endtask

  task automatic test_back_to_back;
    int t1, t2, t3;
    logic [12:0] snap;
    out_ready = 1'b1;
    send(OP_AND, 8'hAA, 8'hCC, mk(8'h88, 0, 0, 1, 0, 0), t1);
    send(OP_OR,  8'hAA, 8'hCC, mk(8'hEE, 0, 0, 1, 0, 0), t2);
    send(OP_XOR, 8'hAA, 8'hCC, mk(8'h66, 0, 0, 0, 0, 0), t3);
    checks++;
    if ((t2 - t1) !== 1 || (t3 - t2) !== 1) begin
      errors++; $display("FAIL b2b_spacing: accept gaps %0d,%0d, required 1,1", t2 - t1, t3 - t2);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; op = OP_ADD; a = 8'd1; b = 8'd2;
    #1;
    snap = {y, carry, zero, neg, ovf, err};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({y, carry, zero, neg, ovf, err} !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d out=%04h in_ready=%0b out_valid=%0b, required out=%04h in_ready=0 out_valid=1",
                 i, {y, carry, zero, neg, ovf, err}, in_ready, out_valid, snap);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(OP_ADD, 8'd1, 8'd2, mk(8'd3, 0, 0, 0, 0, 0), t1);
  endtask

  task automatic test_shift;
    int t;
    out_ready = 1'b1;
    send(OP_SHL, 8'h81, 8'h00, mk(8'h02, 1, 0, 0, 0, 0), t);
    send(OP_SAR, 8'h81, 8'h00, mk(8'hC0, 1, 0, 1, 0, 0), t);
    send(OP_SHR, 8'h81, 8'h00, mk(8'h40, 1, 0, 0, 0, 0), t);
    send(OP_ROL, 8'h81, 8'h00, mk(8'h03, 1, 0, 0, 0, 0), t);
    send(OP_ROR, 8'h81, 8'h00, mk(8'hC0, 1, 0, 1, 0, 0), t);
    send(OP_NOT, 8'h81, 8'h00, mk(8'h7E, 0, 0, 0, 0, 0), t);
    send(4'hF,   8'h81, 8'h42, mk(8'h00, 0, 1, 0, 0, 1), t);
    checks++;
    if (err !== 1'b1 || y !== 8'h00) begin
      errors++; $display("FAIL illegal_op: err=%0b y=%02h, required err=1 y=00", err, y);
    end
    send(4'hE,   8'hFF, 8'hFF, mk(8'h00, 0, 1, 0, 0, 1), t);
  endtask

  task automatic test_mul_reset;
    int t;
    logic seen;
    out_ready = 1'b1;
    send(OP_MUL, 8'd20, 8'd20, mk(8'd144, 1, 0, 1, 0, 0), t);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, y, carry, zero, neg, ovf, err, in_ready} !== 15'h0) begin
      errors++;
      $display("FAIL reset_mid_mul: got %04h, required 0000", {out_valid, y, carry, zero, neg, ovf, err, in_ready});
    end
    sb.delete();
    model_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_mul_ghost: out_valid=%0b after release, required 0", seen);
    end
    send(OP_ADD, 8'd1, 8'd1, mk(8'd2, 0, 0, 0, 0, 0), t);
  endtask

  task automatic test_random;
    int t;
    logic [3:0] o;
    logic [7:0] x, w;
    for (int i = 0; i < 80; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 8'($urandom);
      w = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      send(o, x, w, model(o, int'(x), int'(w), model_c), t);
    end
  endtask

  task automatic test_drain;
    int k;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_back_to_back();
    test_shift();
    test_mul_reset();
    test_random();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operands/op presented.
REQ-005 in_ready  output  1  block accepts the operation this cycle.
REQ-006 a, b  input  WIDTH  operands.
REQ-007 op  input  4  opcode (REQ-012).
REQ-008 out_valid  output  1  result/flags valid.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 y  output  WIDTH  result.
REQ-011 carry, zero, neg, ovf, err  output  1 each  flags registered with y.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by 1, 7 SHR a by 1 (logical), 8 ADC, 9 SBB, A MUL, B ROL, C ROR, D SAR; E and F illegal.
REQ-013 Transfer in: in_valid && in_ready at a rising edge; a, b, op captured in that edge.
REQ-014 Transfer out: out_valid && out_ready at a rising edge; out_valid drops next cycle unless a new result completes on the same edge.
REQ-015 States: IDLE, BUSY, DONE; IDLE->DONE on accepting a non-MUL op; IDLE->BUSY on accepting MUL; BUSY->DONE after WIDTH iterations; DONE->IDLE on transfer out with no new accept.
REQ-016 in_ready = (state==IDLE) || (state==DONE && out_ready); an accept in DONE with out_ready shall go directly to DONE/BUSY (back-to-back, one op per cycle for non-MUL).
REQ-017 Non-MUL latency: out_valid high on the edge that accepts the op (result visible the cycle after acceptance).
REQ-018 MUL: radix-2 shift-add, one bit per cycle; out_valid asserted exactly WIDTH+1 cycles after the accept edge; y = low WIDTH bits of a*b (unsigned).
REQ-019 While out_valid && !out_ready, y and all flags shall hold stable and in_ready shall be 0.
REQ-020 Arithmetic computed in WIDTH+1 bits; ADD/ADC carry = bit WIDTH; SUB/SBB carry = borrow (1 when a < b + cin).
REQ-021 ADC uses a+b+C, SBB uses a-b-C, where C is the carry flag stored by the previous completed op.
REQ-022 carry for SHL/ROL = a[WIDTH-1]; SHR/ROR/SAR = a[0]; MUL = 1 iff high half of product nonzero; logic ops and illegal op = 0.
REQ-023 zero = (y==0); neg = y[WIDTH-1]; ovf = signed overflow for ADD/ADC/SUB/SBB, else 0.
REQ-024 Illegal op: y=0, err=1, carry=0, zero=1, latency as REQ-017; err=0 for all legal ops.
REQ-025 Stored carry C updated only when a result is written to the output register.
REQ-026 in_valid low or in_ready low: no state change except MUL progress.

Reset
REQ-027 rst_n low immediately forces state IDLE, out_valid=0, y=0, all flags 0, stored C=0, MUL iteration discarded; in_ready=0 while rst_n low, 1 on the first cycle after release.
REQ-028 Reset mid-MUL shall produce no out_valid for that op after release.

Verification (WIDTH=8)
REQ-029 ADD a=200 b=100 -> y=44, carry=1, zero=0, ovf=0; then ADC a=1 b=1 -> y=3, carry=0.
REQ-030 SUB a=5 b=5 -> y=0, zero=1, carry=0; SUB a=3 b=10 -> y=249, carry=1, neg=1.
REQ-031 MUL a=20 b=20 -> y=144, carry=1, out_valid exactly 9 cycles after accept, in_ready=0 while BUSY; MUL 15*17 -> y=255, carry=0.
REQ-032 Back-to-back AND/OR/XOR on 8'hAA, 8'hCC with out_ready=1 -> y=88, EE, 66 on consecutive cycles; then out_ready=0 for 3 cycles -> y/flags stable, in_ready=0.
REQ-033 SHL a=8'h81 -> y=02, carry=1; SAR a=8'h81 -> y=C0, carry=1; op=F -> y=0, err=1.
REQ-034 rst_n pulsed low 4 cycles into MUL -> outputs 0 immediately, no out_valid after release, next ADD 1+1 -> y=2, carry=0.
